// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, single-outstanding imem fetch, fetch queue and IF/ID register (optional FETCH_QUEUE_BYPASS_EN)
module fetch_stage #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  input  logic                   br_taken_e,
  input  logic [XLEN-1:0]        br_target_e,
  input  logic                   pc_wb_valid,
  input  logic [XLEN-1:0]        pc_wb_target,
  input  logic                   stall_d,
  input  logic                   flush_d,
  output logic [31:0]            instr_d,
  output logic [XLEN-1:0]        pc_d,
  output logic [XLEN-1:0]        pc_plus4_d,
  output logic                   valid_d,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [XLEN-1:0] r_pcf;
  logic [XLEN-1:0] r_addr;
  logic            r_out;
  logic            r_disc;
  logic [31:0]     r_qi [DEPTH];
  logic [XLEN-1:0] r_qp [DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [AW:0]     r_cnt;
  logic            w_redir;
  logic [XLEN-1:0] w_tgt;
  logic            w_acc;
  logic            w_push;
  logic            w_pop;
  logic            w_byp;
  logic            w_hv;
  logic [31:0]     w_ni;
  logic [XLEN-1:0] w_np;
  assign w_redir   = br_taken_e | pc_wb_valid;
  assign w_tgt     = br_taken_e ? br_target_e : pc_wb_target;
  // An outstanding request is held until acked; a new one needs queue room and no redirect this cycle.
  assign imem_req  = !rst && (r_out || (!w_redir && r_cnt < FULL));
  assign imem_addr = r_out ? r_addr : r_pcf;
  assign w_acc     = imem_req && imem_ack && !w_redir && !r_disc;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_byp     = w_acc && r_cnt == '0 && !stall_d && !flush_d;
`else
  assign w_byp     = 1'b0;
`endif
  assign w_push    = w_acc && !w_byp;
  assign w_pop     = !flush_d && !stall_d && !w_redir && r_cnt != '0;
  assign w_hv      = w_byp | w_pop;
  assign w_ni      = w_byp ? imem_rdata : w_pop ? r_qi[r_rp] : '0;
  assign w_np      = w_byp ? imem_addr : w_pop ? r_qp[r_rp] : '0;
  assign q_count   = r_cnt;
  // Fetch PC, outstanding-request tracking and discard flag for acks made stale by a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcf  <= RESET_PC;
      r_addr <= '0;
      r_out  <= 1'b0;
      r_disc <= 1'b0;
    end else begin
      r_pcf  <= w_redir ? w_tgt : w_acc ? imem_addr + XLEN'(4) : r_pcf;
      r_addr <= imem_addr;
      r_out  <= imem_req && !imem_ack;
      r_disc <= imem_req && !imem_ack && (r_disc || w_redir);
    end
  end
  // Queue pointers and occupancy; a redirect empties the queue by catching the read pointer up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_push);
      r_rp  <= w_redir ? r_wp : r_rp + AW'(w_pop);
      r_cnt <= w_redir ? '0 : r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  // Queue storage needs no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_qi[r_wp] <= imem_rdata;
      r_qp[r_wp] <= imem_addr;
    end
  end
  // IF/ID register: flush beats stall beats load; an empty queue or redirect loads a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush_d) begin
      valid_d    <= 1'b0;
      instr_d    <= '0;
      pc_d       <= '0;
      pc_plus4_d <= '0;
    end else if (!stall_d) begin
      valid_d    <= w_hv;
      instr_d    <= w_ni;
      pc_d       <= w_np;
      pc_plus4_d <= w_hv ? w_np + XLEN'(4) : '0;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random checks of fetch_stage against an in-order instruction stream model
module tb_fetch_stage;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        br_taken_e = 1'b0;
  logic [31:0] br_target_e = '0;
  logic        pc_wb_valid = 1'b0;
  logic [31:0] pc_wb_target = '0;
  logic        stall_d = 1'b0;
  logic        flush_d = 1'b0;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic [2:0]  q_count;
  int checks = 0;
  int errors = 0;
  int delivered = 0;
  int ack_lat = 0;
  int lat = 0;
  bit busy = 1'b0;
  logic [31:0] exp_pc = RESET_PC;
  logic        p_req, p_ack, p_stall, p_flush, p_redir;
  logic [31:0] p_addr, p_tgt, held;
  logic [96:0] p_out;

  fetch_stage #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .br_taken_e(br_taken_e), .br_target_e(br_target_e),
    .pc_wb_valid(pc_wb_valid), .pc_wb_target(pc_wb_target), .stall_d(stall_d), .flush_d(flush_d),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .q_count(q_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = mem_f(imem_addr);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: memory responds, the edge happens, then the stream model judges IF/ID.
  task automatic step();
    #1;
    if (imem_req) begin
      if (!busy) begin
        busy = 1'b1;
        lat = (ack_lat < 0) ? int'($urandom_range(0, 3)) : ack_lat;
      end
      imem_ack = (lat == 0);
      if (lat == 0) busy = 1'b0;
      else lat--;
    end else begin
      imem_ack = 1'b0;
      busy = 1'b0;
    end
    p_req = imem_req;
    p_ack = imem_ack;
    p_addr = imem_addr;
    p_stall = stall_d;
    p_flush = flush_d;
    p_redir = br_taken_e | pc_wb_valid;
    p_tgt = br_taken_e ? br_target_e : pc_wb_target;
    p_out = {valid_d, instr_d, pc_d, pc_plus4_d};
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    if (p_flush) chk("flush", {valid_d, instr_d, pc_d, pc_plus4_d}, '0);
    else if (p_stall) chk("stall_hold", {valid_d, instr_d, pc_d, pc_plus4_d}, p_out);
    else if (p_redir) chk("redir_bubble", {valid_d, instr_d}, '0);
    else if (valid_d) begin
      chk("stream", {instr_d, pc_d, pc_plus4_d}, {mem_f(exp_pc), exp_pc, exp_pc + 32'd4});
      exp_pc += 32'd4;
      delivered++;
    end else chk("bubble", instr_d, '0);
    if (p_redir) exp_pc = p_tgt;
    if (p_req && !p_ack) chk("req_stable", {imem_req, imem_addr}, {1'b1, p_addr});
    chk("q_bound", q_count <= DEPTH, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_q", q_count, 0);
    chk("rst_ifid", {valid_d, instr_d, pc_d, pc_plus4_d}, '0);
    chk("rst_addr", imem_addr, RESET_PC);
    rst = 1'b0;
    #1;
    chk("first_req", {imem_req, imem_addr}, {1'b1, RESET_PC});
    for (int k = 0; k < 8; k++) begin
      chk("seq_addr", imem_addr, 32'(4 * k));
      chk("seq_valid", valid_d, k >= LAT);
      if (k >= LAT) chk("seq_pc", pc_d, 32'(4 * (k - LAT)));
      step();
    end
    chk("steady_q", q_count, LAT - 1);
    stall_d = 1'b1;
    repeat (6) step();
    #1;
    chk("stall_q", q_count, DEPTH);
    chk("stall_req", imem_req, 0);
    stall_d = 1'b0;
    held = pc_d;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("drain_pc", {valid_d, pc_d}, {1'b1, held + 32'(4 * k)});
    end
    br_taken_e = 1'b1;
    br_target_e = 32'h100;
    pc_wb_valid = 1'b1;
    pc_wb_target = 32'h200;
    step();
    br_taken_e = 1'b0;
    pc_wb_valid = 1'b0;
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_q", q_count, 0);
    chk("redir_valid", valid_d, 0);
    repeat (6) step();
    ack_lat = 3;
    #1;
    chk("d_addr0", {imem_req, imem_addr}, {1'b1, 32'h118});
    step();
    br_taken_e = 1'b1;
    br_target_e = 32'h40;
    step();
    br_taken_e = 1'b0;
    chk("d_hold1", {imem_req, imem_addr}, {1'b1, 32'h118});
    chk("d_q1", q_count, 0);
    step();
    chk("d_hold2", {imem_req, imem_addr}, {1'b1, 32'h118});
    step();
    #1;
    chk("d_new", {imem_req, imem_addr}, {1'b1, 32'h40});
    chk("d_q2", q_count, 0);
    ack_lat = 0;
    repeat (6) step();
    stall_d = 1'b1;
    flush_d = 1'b1;
    step();
    stall_d = 1'b0;
    flush_d = 1'b0;
    chk("fs_clear", {valid_d, instr_d}, '0);
    repeat (4) step();
    ack_lat = 3;
    step();
    rst = 1'b1;
    #1;
    chk("r_req", imem_req, 0);
    chk("r_state", {q_count, valid_d, instr_d, pc_d, pc_plus4_d}, '0);
    chk("r_addr", imem_addr, RESET_PC);
    imem_ack = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    imem_ack = 1'b0;
    chk("r_late_ack", {q_count, valid_d}, '0);
    rst = 1'b0;
    busy = 1'b0;
    exp_pc = RESET_PC;
    #1;
    chk("rs_req", {imem_req, imem_addr}, {1'b1, RESET_PC});
    repeat (10) step();
    ack_lat = -1;
    for (int i = 0; i < 800; i++) begin
      int r;
      stall_d = ($urandom % 5) == 0;
      flush_d = ($urandom % 20) == 0;
      r = int'($urandom % 25);
      br_taken_e = (r == 0) || (r == 2);
      pc_wb_valid = (r == 1) || (r == 2);
      br_target_e = {20'($urandom_range(0, 1023)), 12'h0} | {22'h0, 8'($urandom), 2'b00};
      pc_wb_target = {22'h0, 8'($urandom), 2'b00};
      step();
    end
    stall_d = 1'b0;
    flush_d = 1'b0;
    br_taken_e = 1'b0;
    pc_wb_valid = 1'b0;
    repeat (8) step();
    chk("delivered", delivered > 200, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC/address width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning fetch queue entries (power of 2, >=2).
REQ-003 SHALL have parameter RESET_PC, default 0, meaning PC loaded at reset.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port imem_req  out  1  instruction fetch request.
REQ-007 SHALL have port imem_addr  out  XLEN  fetch address.
REQ-008 SHALL have port imem_ack  in  1  fetch data valid; may assert in the same cycle as imem_req.
REQ-009 SHALL have port imem_rdata  in  32  fetched instruction.
REQ-010 SHALL have port br_taken_e  in  1  execute-stage branch redirect.
REQ-011 SHALL have port br_target_e  in  XLEN  branch target (ALU result).
REQ-012 SHALL have port pc_wb_valid  in  1  writeback writes PC.
REQ-013 SHALL have port pc_wb_target  in  XLEN  writeback PC value.
REQ-014 SHALL have port stall_d  in  1  hold the IF/ID register.
REQ-015 SHALL have port flush_d  in  1  clear the IF/ID register.
REQ-016 SHALL have ports instr_d (32), pc_d (XLEN), pc_plus4_d (XLEN), valid_d (1), all out, as IF/ID register contents.
REQ-017 SHALL have port q_count  out  $clog2(DEPTH)+1  fetch queue occupancy.

Function
REQ-018 SHALL hold fetch PC pcf; imem_addr SHALL equal pcf, or the latched address while a request is outstanding.
REQ-019 SHALL assert imem_req only when q_count + outstanding < DEPTH; at most one request outstanding; imem_req and imem_addr stable until imem_ack.
REQ-020 On imem_ack (not discarded), SHALL push {imem_rdata, address} into the queue and set pcf <= address + 4 (mod 2^XLEN).
REQ-021 Redirect priority: br_taken_e over pc_wb_valid; on redirect, pcf <= selected target next cycle and the queue empties.
REQ-022 Redirect with a request outstanding SHALL let it complete unchanged; its ack data SHALL be discarded and the new fetch issued the cycle after the ack.
REQ-023 Redirect coincident with an ack SHALL discard that ack's data.
REQ-024 IF/ID update priority: flush_d, then stall_d, then load.
REQ-025 flush_d SHALL set instr_d=0, pc_d=0, pc_plus4_d=0, valid_d=0 next cycle.
REQ-026 stall_d (no flush) SHALL hold all IF/ID outputs and not pop the queue.
REQ-027 Load with non-empty queue SHALL pop the head into IF/ID with valid_d=1, pc_plus4_d=pc_d+4; with empty queue SHALL insert a bubble (valid_d=0, instr_d=0).
REQ-028 Simultaneous push and pop SHALL leave q_count unchanged; a full queue SHALL never be pushed.
REQ-029 Pop SHALL not occur in a redirect cycle; IF/ID loads a bubble then.
REQ-030 Queue pointers SHALL wrap modulo DEPTH.

Reset
REQ-031 While rst=1: pcf=RESET_PC, queue empty, q_count=0, imem_req=0, IF/ID outputs 0, outstanding and discard flags cleared.
REQ-032 First imem_req SHALL assert in the first cycle after rst deasserts; rst mid-transaction SHALL abandon the request and ignore any later ack for it.

Configuration
REQ-033 Macro FETCH_QUEUE_BYPASS_EN: when defined, an accepted ack with empty queue, no stall_d/flush_d/redirect SHALL load IF/ID directly that cycle (ack-to-valid_d latency 1); when undefined, all ack data goes through the queue (latency 2).

Verification
REQ-034 Reset release, imem_ack tied 1, RESET_PC=0 -> imem_addr 0,4,8,...; valid_d=1 with pc_d=0 at cycle 2 (cycle 1 with bypass), then one instruction per cycle.
REQ-035 stall_d held 6 cycles, ack tied 1, DEPTH=4 -> q_count saturates at 4, imem_req drops, IF/ID holds pc_d; release -> pc_d advances by 4 each cycle, none lost.
REQ-036 br_taken_e=1, br_target_e=0x100 with pc_wb_valid=1, pc_wb_target=0x200 -> next imem_addr=0x100, q_count=0.
REQ-037 imem_ack delayed 3 cycles, redirect to 0x40 at cycle 1 -> addr stays old until ack, data discarded, next request addr 0x40.
REQ-038 flush_d and stall_d both 1 -> valid_d=0, instr_d=0 next cycle.
REQ-039 rst pulsed with a request outstanding -> all outputs reset, late ack ignored, fetch restarts at RESET_PC.
